// File: rtl/rf_pkg.sv
// Shared types and sizes for the integer register file.
package rf_pkg;
  localparam int XLEN         = 32;
  localparam int NREGS        = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_RD_PORTS = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [NREGS-1:0][XLEN-1:0] rf_view_t;

  typedef struct packed {
    logic      wen;
    reg_addr_t waddr;
    xlen_t     wdata;
  } wr_req_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: x0 returns zero, optional same-cycle write forwarding.
module rf_read_port
  import rf_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b0
) (
  input  reg_addr_t raddr,
  input  rf_view_t  rf,
  input  wr_req_t   wr,
  output xlen_t     rdata
);

  generate
    if (BYPASS_EN) begin : g_bp
      always_comb begin
        rdata = rf[raddr];
        if (raddr == '0)
          rdata = '0;
        else if (wr.wen && wr.waddr == raddr)
          rdata = wr.wdata;
      end
    end else begin : g_nb
      // No forwarding: the write request is deliberately left out of the read path.
      logic unused_wr;
      assign unused_wr = ^wr;
      assign rdata     = (raddr == '0) ? '0 : rf[raddr];
    end
  endgenerate

endmodule

// File: rtl/reg_file.sv
// RISC-V integer register file: x1..x31 storage, x0 hardwired zero, two read ports, one write port.
module reg_file
  import rf_pkg::*;
#(
  parameter bit BYPASS_EN = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_rs1_raddr,
  output logic [31:0] o_rs1_rdata,
  input  logic [4:0]  i_rs2_raddr,
  output logic [31:0] o_rs2_rdata,
  input  logic        i_rd_wen,
  input  logic [4:0]  i_rd_waddr,
  input  logic [31:0] i_rd_wdata
);

  logic [NREGS-1:1][XLEN-1:0]               rf_q;
  rf_view_t                                 rf_view;
  wr_req_t                                  wr;
  logic [NUM_RD_PORTS-1:0][REG_ADDR_W-1:0]  rd_addr;
  logic [NUM_RD_PORTS-1:0][XLEN-1:0]        rd_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rf_q <= '0;
    end else if (i_rd_wen) begin
      for (int i = 1; i < NREGS; i++)
        if (i_rd_waddr == reg_addr_t'(i)) rf_q[i] <= i_rd_wdata;
    end
  end

  assign rf_view = {rf_q, {XLEN{1'b0}}};

  // Reset drops the write, so it must not be forwarded either.
  assign wr.wen   = i_rd_wen & ~i_rst;
  assign wr.waddr = i_rd_waddr;
  assign wr.wdata = i_rd_wdata;

  assign rd_addr = {i_rs2_raddr, i_rs1_raddr};

  generate
    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rp
      rf_read_port #(.BYPASS_EN(BYPASS_EN)) u_rp (
        .raddr (rd_addr[p]),
        .rf    (rf_view),
        .wr    (wr),
        .rdata (rd_data[p])
      );
    end
  endgenerate

  assign o_rs1_rdata = rd_data[0];
  assign o_rs2_rdata = rd_data[1];

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: both BYPASS_EN builds driven in lockstep against an array model.
module tb_reg_file;
  import rf_pkg::*;

  logic      clk = 1'b0;
  logic      rst, wen;
  reg_addr_t rs1, rs2, waddr;
  xlen_t     wdata;
  xlen_t     nb1, nb2, bp1, bp2;

  int    checks = 0;
  int    errors = 0;
  xlen_t model [NREGS];

  always #5 clk = ~clk;

  reg_file #(.BYPASS_EN(1'b0)) u_nb (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_raddr(rs1), .o_rs1_rdata(nb1),
    .i_rs2_raddr(rs2), .o_rs2_rdata(nb2),
    .i_rd_wen(wen), .i_rd_waddr(waddr), .i_rd_wdata(wdata)
  );

  reg_file #(.BYPASS_EN(1'b1)) u_bp (
    .i_clk(clk), .i_rst(rst),
    .i_rs1_raddr(rs1), .o_rs1_rdata(bp1),
    .i_rs2_raddr(rs2), .o_rs2_rdata(bp2),
    .i_rd_wen(wen), .i_rd_waddr(waddr), .i_rd_wdata(wdata)
  );

  task automatic chk(input string tag, input xlen_t obs, input xlen_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Architectural read rule: x0 is zero, forward a live write when bypassing, else the stored value.
  function automatic xlen_t exp_rd(input reg_addr_t a, input bit bp);
    if (a == 0) return 32'h0;
    if (bp && !rst && wen && waddr == a) return wdata;
    return model[a];
  endfunction

  task automatic set(input logic r, input logic we, input reg_addr_t wa, input xlen_t wd,
                     input reg_addr_t a1, input reg_addr_t a2);
    rst = r; wen = we; waddr = wa; wdata = wd; rs1 = a1; rs2 = a2;
  endtask

  task automatic check_all(input string tag);
    #1;
    chk({tag, "_nb_rs1"}, nb1, exp_rd(rs1, 1'b0));
    chk({tag, "_nb_rs2"}, nb2, exp_rd(rs2, 1'b0));
    chk({tag, "_bp_rs1"}, bp1, exp_rd(rs1, 1'b1));
    chk({tag, "_bp_rs2"}, bp2, exp_rd(rs2, 1'b1));
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    end else if (wen && waddr != 0) begin
      model[waddr] = wdata;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    set(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();

    // Reset state
    set(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd31);
    check_all("reset");
    chk("reset_x5_const", bp1, 32'h0);

    // Standard write/read
    set(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    step();
    set(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    check_all("wr5");
    chk("wr5_nb", nb1, 32'hDEADBEEF);
    chk("wr5_bp", bp1, 32'hDEADBEEF);

    // x0 protection
    set(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    check_all("x0_wr");
    step();
    set(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check_all("x0_rd");
    chk("x0_nb_rs2", nb2, 32'h0);
    chk("x0_bp_rs1", bp1, 32'h0);

    // Bypass vs no bypass, sampled before the edge
    set(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    step();
    set(1'b0, 1'b1, 5'd10, 32'hCAFEBABE, 5'd10, 5'd0);
    check_all("byp_pre");
    chk("byp_pre_nb", nb1, 32'h0);
    chk("byp_pre_bp", bp1, 32'hCAFEBABE);
    step();
    set(1'b0, 1'b0, 5'd0, 32'h0, 5'd10, 5'd10);
    chk("byp_post_nb", nb1, 32'hCAFEBABE);
    chk("byp_post_bp", bp1, 32'hCAFEBABE);

    // Dual-port independence
    set(1'b0, 1'b1, 5'd1, 32'h11111111, 5'd0, 5'd0);
    step();
    set(1'b0, 1'b1, 5'd2, 32'h22222222, 5'd0, 5'd0);
    step();
    set(1'b0, 1'b0, 5'd0, 32'h0, 5'd2, 5'd1);
    check_all("dual");
    chk("dual_nb_rs1", nb1, 32'h22222222);
    chk("dual_nb_rs2", nb2, 32'h11111111);
    set(1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd1);
    #1;
    chk("same_bp_rs1", bp1, 32'h11111111);
    chk("same_bp_rs2", bp2, 32'h11111111);

    // Reset priority over a simultaneous write
    set(1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd0, 5'd0);
    step();
    set(1'b1, 1'b1, 5'd7, 32'h5A5A5A5A, 5'd7, 5'd7);
    check_all("rstpri_pre");
    chk("rstpri_bp_stored", bp1, 32'hA5A5A5A5);
    step();
    set(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    chk("rstpri_nb", nb1, 32'h0);
    chk("rstpri_bp", bp2, 32'h0);

    // Bypass to x0 and mismatched address
    set(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    #1;
    chk("byp_x0", bp1, 32'h0);
    set(1'b0, 1'b1, 5'd4, 32'h12345678, 5'd0, 5'd0);
    step();
    set(1'b0, 1'b1, 5'd3, 32'hBBBBBBBB, 5'd4, 5'd3);
    check_all("byp_miss");
    chk("byp_miss_rs1", bp1, 32'h12345678);
    chk("byp_hit_rs2", bp2, 32'hBBBBBBBB);
    step();

    // Randomized traffic, with occasional reset and frequent address collisions
    for (int n = 0; n < 400; n++) begin
      set(($urandom_range(39) == 0), ($urandom_range(3) != 0),
          reg_addr_t'($urandom_range(31)), xlen_t'($urandom),
          reg_addr_t'($urandom_range(31)), reg_addr_t'($urandom_range(31)));
      if ($urandom_range(3) == 0) rs1 = waddr;
      if ($urandom_range(3) == 0) rs2 = waddr;
      check_all("rand");
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
